// File: rtl/mipi_dphy_pkg.sv
// Shared D-PHY transmit definitions: burst state encoding, sync byte and LP line levels.
// LP levels are packed {Dp, Dn}.
package mipi_dphy_pkg;

  typedef enum logic [2:0] {
    STOP,
    LPX,
    PREPARE,
    ZERO,
    SYNC,
    HST,
    TRAIL,
    EXIT
  } dphy_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef logic [1:0] lp_t;
  localparam lp_t LP11 = 2'b11;
  localparam lp_t LP01 = 2'b01;
  localparam lp_t LP00 = 2'b00;

  // Trail holds the inverse of the last serialized bit; bytes go out LSB first, so that is bit 7.
  function automatic logic [7:0] trail_byte(input logic [7:0] last_byte);
    return {8{~last_byte[7]}};
  endfunction

endpackage

// File: rtl/mipi_dphy_interval_timer.sv
// Loadable down-counter for D-PHY LP/HS interval timing; counts down to zero and holds there.
module mipi_dphy_interval_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_hs,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk_hs or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mipi_dphy_tx_lanes.sv
// D-PHY transmit data-lane controller: sequences LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync ->
// payload -> trail -> exit for 1..4 lock-stepped lanes, one byte per lane per clock.
module mipi_dphy_tx_lanes
  import mipi_dphy_pkg::*;
#(
  parameter int NUM_DATA_LANES = 2,
  parameter int T_LPX          = 4,
  parameter int T_HS_PREPARE   = 3,
  parameter int T_HS_ZERO      = 6,
  parameter int T_HS_TRAIL     = 5,
  parameter int T_HS_EXIT      = 8,
  parameter int CNT_W          = 8
) (
  input  logic                        clk_hs,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        hs_req,
  input  logic [8*NUM_DATA_LANES-1:0] data,
  output logic                        re,
  output logic [8*NUM_DATA_LANES-1:0] hs_data,
  output logic                        hs_oe,
  output logic [NUM_DATA_LANES-1:0]   lp_p,
  output logic [NUM_DATA_LANES-1:0]   lp_n,
  output logic                        busy
);

  localparam int DW = 8 * NUM_DATA_LANES;

  localparam logic [CNT_W-1:0] LPX_LOAD     = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0] PREPARE_LOAD = CNT_W'(T_HS_PREPARE - 1);
  localparam logic [CNT_W-1:0] ZERO_LOAD    = CNT_W'(T_HS_ZERO - 1);
  localparam logic [CNT_W-1:0] TRAIL_LOAD   = CNT_W'(T_HS_TRAIL - 1);
  localparam logic [CNT_W-1:0] EXIT_LOAD    = CNT_W'(T_HS_EXIT - 1);

  dphy_state_e      state_reg;
  lp_t              lp_reg;
  logic             hs_oe_reg;
  logic             busy_reg;
  logic [DW-1:0]    hs_data_reg;
  logic [DW-1:0]    trail_data;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_zero;

  // The timer is reloaded on every edge that leaves a state, with the next state's length.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_reg)
      STOP:    if (enable && hs_req) begin timer_load = 1'b1; timer_val = LPX_LOAD;     end
      LPX:     if (timer_zero)       begin timer_load = 1'b1; timer_val = PREPARE_LOAD; end
      PREPARE: if (timer_zero)       begin timer_load = 1'b1; timer_val = ZERO_LOAD;    end
      HST:     if (!hs_req)          begin timer_load = 1'b1; timer_val = TRAIL_LOAD;   end
      TRAIL:   if (timer_zero)       begin timer_load = 1'b1; timer_val = EXIT_LOAD;    end
      default: ;
    endcase
  end

  mipi_dphy_interval_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_hs   (clk_hs),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DATA_LANES; gi++) begin : g_lane
      assign trail_data[8*gi +: 8] = trail_byte(hs_data_reg[8*gi +: 8]);
      assign lp_p[gi] = lp_reg[1];
      assign lp_n[gi] = lp_reg[0];
    end
  endgenerate

  always_ff @(posedge clk_hs or posedge reset) begin
    if (reset) begin
      state_reg   <= STOP;
      lp_reg      <= LP11;
      hs_oe_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      hs_data_reg <= '0;
    end else begin
      unique case (state_reg)
        STOP: if (enable && hs_req) begin
          state_reg <= LPX;
          lp_reg    <= LP01;
          busy_reg  <= 1'b1;
        end
        LPX: if (timer_zero) begin
          state_reg <= PREPARE;
          lp_reg    <= LP00;
        end
        PREPARE: if (timer_zero) begin
          state_reg   <= ZERO;
          hs_oe_reg   <= 1'b1;
          hs_data_reg <= '0;
        end
        ZERO: if (timer_zero) begin
          state_reg   <= SYNC;
          hs_data_reg <= {NUM_DATA_LANES{SYNC_BYTE}};
        end
        SYNC: state_reg <= HST;
        // hs_data_reg always holds the last byte sent, so the trail level derives from it directly.
        HST: begin
          if (hs_req) begin
            hs_data_reg <= data;
          end else begin
            state_reg   <= TRAIL;
            hs_data_reg <= trail_data;
          end
        end
        TRAIL: if (timer_zero) begin
          state_reg   <= EXIT;
          lp_reg      <= LP11;
          hs_oe_reg   <= 1'b0;
          hs_data_reg <= '0;
        end
        EXIT: if (timer_zero) begin
          state_reg <= STOP;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= STOP;
      endcase
    end
  end

  assign re      = (state_reg == HST) && hs_req;
  assign hs_data = hs_data_reg;
  assign hs_oe   = hs_oe_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_mipi_dphy_tx_lanes.sv
// Bench for mipi_dphy_tx_lanes: default 2-lane instance with a payload scoreboard, plus
// 1-lane and 4-lane instances with all intervals set to one cycle.
module tb_mipi_dphy_tx_lanes;

  logic clk_hs = 1'b0;
  always #5 clk_hs = ~clk_hs;

  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic        hs_req = 1'b0;
  logic [15:0] data   = '0;
  logic        re, hs_oe, busy;
  logic [15:0] hs_data;
  logic [1:0]  lp_p, lp_n;

  logic        en_s  = 1'b0;
  logic        req_s = 1'b0;
  logic [31:0] d4    = '0;
  logic        re4, oe4, busy4, re1, oe1, busy1;
  logic [31:0] hs4;
  logic [7:0]  hs1;
  logic [3:0]  lpp4, lpn4;
  logic        lpp1, lpn1;

  mipi_dphy_tx_lanes dut (
    .clk_hs(clk_hs), .reset(reset), .enable(enable), .hs_req(hs_req), .data(data),
    .re(re), .hs_data(hs_data), .hs_oe(hs_oe), .lp_p(lp_p), .lp_n(lp_n), .busy(busy)
  );

  mipi_dphy_tx_lanes #(
    .NUM_DATA_LANES(4), .T_LPX(1), .T_HS_PREPARE(1), .T_HS_ZERO(1), .T_HS_TRAIL(1), .T_HS_EXIT(1)
  ) dut4 (
    .clk_hs(clk_hs), .reset(reset), .enable(en_s), .hs_req(req_s), .data(d4),
    .re(re4), .hs_data(hs4), .hs_oe(oe4), .lp_p(lpp4), .lp_n(lpn4), .busy(busy4)
  );

  mipi_dphy_tx_lanes #(
    .NUM_DATA_LANES(1), .T_LPX(1), .T_HS_PREPARE(1), .T_HS_ZERO(1), .T_HS_TRAIL(1), .T_HS_EXIT(1)
  ) dut1 (
    .clk_hs(clk_hs), .reset(reset), .enable(en_s), .hs_req(req_s), .data(d4[7:0]),
    .re(re1), .hs_data(hs1), .hs_oe(oe1), .lp_p(lpp1), .lp_n(lpn1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected beats are queued when the bench sees the DUT will take them;
  // the monitor pops one each cycle after an accepting edge.
  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;
  logic        took = 1'b0;
  int          accepted = 0;

  always @(posedge clk_hs) took <= re;

  always @(negedge clk_hs) begin
    if (took) begin
      accepted++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got beat %h expected none", hs_data);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("payload", {16'h0, hs_data}, {16'h0, sb_exp});
        $display("beat %0d hs_data=%h expected=%h", accepted, hs_data, sb_exp);
      end
    end
  end

  // Trail byte per lane: inverse of the last bit on the wire (bit 7, LSB-first serializer).
  function automatic logic [15:0] trail2(input logic [15:0] last);
    return {{8{~last[15]}}, {8{~last[7]}}};
  endfunction

  task automatic phase(input string name, input int n, input logic [1:0] lp, input bit chk_lp,
                       input logic oe, input logic [15:0] hd, input logic bz);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_hs);
      #1;
      if (chk_lp) begin
        chk({name, "_lp_p"}, {30'h0, lp_p}, {30'h0, {2{lp[1]}}});
        chk({name, "_lp_n"}, {30'h0, lp_n}, {30'h0, {2{lp[0]}}});
      end
      chk({name, "_oe"}, {31'h0, hs_oe}, {31'h0, oe});
      chk({name, "_hs_data"}, {16'h0, hs_data}, {16'h0, hd});
      chk({name, "_busy"}, {31'h0, busy}, {31'h0, bz});
      chk({name, "_re"}, {31'h0, re}, 32'h0);
    end
  endtask

  task automatic payload(input int n, input logic [15:0] p0, input logic [15:0] p1);
    int idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_hs);
      hs_req = (idx < n);
      data   = (idx == 0) ? p0 : p1;
      #1;
      chk("hst_re", {31'h0, re}, {31'h0, hs_req});
      if (!hs_req) break;
      exp_q.push_back(data);
      idx++;
    end
    chk("beats_consumed", idx, n);
  endtask

  task automatic run_burst(input string tag, input int n, input logic [15:0] p0,
                           input logic [15:0] p1, input bit b2b);
    logic [15:0] last;
    last = (n == 0) ? 16'hB8B8 : ((n == 1) ? p0 : p1);
    phase("lpx", 4, 2'b01, 1, 1'b0, 16'h0, 1'b1);
    if (n == 0) begin
      phase("prepare", 1, 2'b00, 1, 1'b0, 16'h0, 1'b1);
      hs_req = 1'b0;
      phase("prepare", 2, 2'b00, 1, 1'b0, 16'h0, 1'b1);
    end else begin
      phase("prepare", 3, 2'b00, 1, 1'b0, 16'h0, 1'b1);
    end
    phase("zero", 1, 2'b00, 0, 1'b1, 16'h0, 1'b1);
    enable = 1'b0;
    phase("zero", 5, 2'b00, 0, 1'b1, 16'h0, 1'b1);
    phase("sync", 1, 2'b00, 0, 1'b1, 16'hB8B8, 1'b1);
    payload(n, p0, p1);
    phase("trail", 5, 2'b00, 0, 1'b1, trail2(last), 1'b1);
    if (b2b) begin
      phase("exit", 1, 2'b11, 1, 1'b0, 16'h0, 1'b1);
      hs_req = 1'b1;
      enable = 1'b1;
      phase("exit", 7, 2'b11, 1, 1'b0, 16'h0, 1'b1);
      phase("gap_stop", 1, 2'b11, 1, 1'b0, 16'h0, 1'b0);
    end else begin
      phase("exit", 8, 2'b11, 1, 1'b0, 16'h0, 1'b1);
      phase("stop", 1, 2'b11, 1, 1'b0, 16'h0, 1'b0);
    end
    $display("burst %s bytes=%0d trail=%h", tag, n, trail2(last));
  endtask

  function automatic logic [31:0] exp_hs4(input int c);
    case (c)
      4, 5:    return 32'hB8B8B8B8;
      6:       return 32'h01807FC3;
      7:       return 32'hFF00FF00;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    int a0;
    repeat (2) @(negedge clk_hs);
    #1;
    phase("in_reset", 1, 2'b11, 1, 1'b0, 16'h0, 1'b0);
    reset  = 1'b0;
    hs_req = 1'b1;
    data   = 16'h1234;
    phase("no_enable", 4, 2'b11, 1, 1'b0, 16'h0, 1'b0);

    enable = 1'b1;
    run_burst("single", 2, 16'h1234, 16'h80FF, 1'b0);

    a0 = accepted;
    enable = 1'b1;
    hs_req = 1'b1;
    run_burst("empty", 0, 16'h0, 16'h0, 1'b0);
    chk("empty_no_re", accepted - a0, 0);

    enable = 1'b1;
    hs_req = 1'b1;
    run_burst("b2b_a", 2, 16'hA55A, 16'h00FF, 1'b1);
    run_burst("b2b_b", 1, 16'h817E, 16'h0, 1'b0);

    // Reset during the first payload cycle.
    enable = 1'b1;
    hs_req = 1'b1;
    phase("r_lpx", 4, 2'b01, 1, 1'b0, 16'h0, 1'b1);
    phase("r_prepare", 3, 2'b00, 1, 1'b0, 16'h0, 1'b1);
    phase("r_zero", 6, 2'b00, 0, 1'b1, 16'h0, 1'b1);
    phase("r_sync", 1, 2'b00, 0, 1'b1, 16'hB8B8, 1'b1);
    @(negedge clk_hs);
    data = 16'hCAFE;
    #1;
    chk("r_hst_re", {31'h0, re}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_lp_p", {30'h0, lp_p}, 32'h3);
    chk("rst_lp_n", {30'h0, lp_n}, 32'h3);
    chk("rst_oe", {31'h0, hs_oe}, 32'h0);
    chk("rst_hs_data", {16'h0, hs_data}, 32'h0);
    chk("rst_re", {31'h0, re}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    $display("reset asserted mid-HST");
    @(negedge clk_hs);
    reset  = 1'b0;
    enable = 1'b0;
    phase("post_reset", 3, 2'b11, 1, 1'b0, 16'h0, 1'b0);
    hs_req = 1'b0;

    // 4-lane and 1-lane instances, every interval one cycle.
    en_s  = 1'b1;
    req_s = 1'b1;
    d4    = 32'h01807FC3;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_hs);
      if (c == 6) req_s = 1'b0;
      #1;
      if (c <= 2 || c >= 8) begin
        chk($sformatf("n4_lp_p_c%0d", c), {28'h0, lpp4}, (c == 1) ? 32'h0 : ((c == 2) ? 32'h0 : 32'hF));
        chk($sformatf("n4_lp_n_c%0d", c), {28'h0, lpn4}, (c == 1) ? 32'hF : ((c == 2) ? 32'h0 : 32'hF));
        chk($sformatf("n1_lp_p_c%0d", c), {31'h0, lpp1}, (c <= 2) ? 32'h0 : 32'h1);
        chk($sformatf("n1_lp_n_c%0d", c), {31'h0, lpn1}, (c == 2) ? 32'h0 : 32'h1);
      end
      chk($sformatf("n4_oe_c%0d", c), {31'h0, oe4}, (c >= 3 && c <= 7) ? 32'h1 : 32'h0);
      chk($sformatf("n1_oe_c%0d", c), {31'h0, oe1}, (c >= 3 && c <= 7) ? 32'h1 : 32'h0);
      chk($sformatf("n4_hs_c%0d", c), hs4, exp_hs4(c));
      chk($sformatf("n1_hs_c%0d", c), {24'h0, hs1}, {24'h0, exp_hs4(c) & 32'hFF});
      chk($sformatf("n4_busy_c%0d", c), {31'h0, busy4}, (c <= 8) ? 32'h1 : 32'h0);
      chk($sformatf("n1_busy_c%0d", c), {31'h0, busy1}, (c <= 8) ? 32'h1 : 32'h0);
      chk($sformatf("n4_re_c%0d", c), {31'h0, re4}, (c == 5) ? 32'h1 : 32'h0);
      chk($sformatf("n1_re_c%0d", c), {31'h0, re1}, (c == 5) ? 32'h1 : 32'h0);
      if (c == 1) en_s = 1'b0;
    end
    $display("short-interval burst N=4 hs=%h N=1 hs=%h", hs4, hs1);

    @(negedge clk_hs);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
